// File: rtl/register_bus_arbiter_pkg.sv
// Shared types for the register-bus arbiter: FSM state encoding and the
// latched request record of the winning master.
package register_bus_arbiter_pkg;

    localparam int REG_ADDR_WIDTH = 8;
    localparam int REG_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] address;
        logic [REG_DATA_WIDTH-1:0] wr_data;
        logic                      wr_enable;
    } reg_request_t;

endpackage

// File: rtl/register_bus_arbiter.sv
// Two-master round-robin arbiter in front of a register file with a
// one-cycle registered read port; every transaction returns one response.
module register_bus_arbiter
    import register_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
    input  logic                  ipClk,
    input  logic                  ipReset,

    input  logic                  ipValid0,
    input  logic [ADDR_WIDTH-1:0] ipAddress0,
    input  logic [DATA_WIDTH-1:0] ipWrData0,
    input  logic                  ipWrEnable0,
    output logic                  opReady0,
    output logic                  opRdValid0,
    output logic [DATA_WIDTH-1:0] opRdData0,

    input  logic                  ipValid1,
    input  logic [ADDR_WIDTH-1:0] ipAddress1,
    input  logic [DATA_WIDTH-1:0] ipWrData1,
    input  logic                  ipWrEnable1,
    output logic                  opReady1,
    output logic                  opRdValid1,
    output logic [DATA_WIDTH-1:0] opRdData1,

    output logic [ADDR_WIDTH-1:0] opAddress,
    output logic [DATA_WIDTH-1:0] opWrData,
    output logic                  opWrEnable,
    input  logic [DATA_WIDTH-1:0] ipRdData
);

    arb_state_t   state, next_state;
    reg_request_t pick;
    logic         take;
    logic         grant_one;
    // Master that won the most recent grant; doubles as the owner of the
    // transaction currently in ISSUE/WAIT.
    logic         last_grant;

    always_ff @(posedge ipClk) begin
        if (ipReset) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        take       = 1'b0;
        grant_one  = 1'b0;
        case (state)
            IDLE: begin
                if (ipValid0 || ipValid1) begin
                    take       = 1'b1;
                    grant_one  = ipValid1 && (!ipValid0 || !last_grant);
                    next_state = ISSUE;
                end
            end
            ISSUE:   next_state = WAIT;
            WAIT:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pick = '0;
        if (grant_one) begin
            pick.address   = REG_ADDR_WIDTH'(ipAddress1);
            pick.wr_data   = REG_DATA_WIDTH'(ipWrData1);
            pick.wr_enable = ipWrEnable1;
        end else begin
            pick.address   = REG_ADDR_WIDTH'(ipAddress0);
            pick.wr_data   = REG_DATA_WIDTH'(ipWrData0);
            pick.wr_enable = ipWrEnable0;
        end
    end

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            last_grant <= 1'b1;
            opAddress  <= '0;
            opWrData   <= '0;
            opWrEnable <= 1'b0;
            opReady0   <= 1'b0;
            opReady1   <= 1'b0;
            opRdValid0 <= 1'b0;
            opRdValid1 <= 1'b0;
            opRdData0  <= '0;
            opRdData1  <= '0;
        end else begin
            opReady0   <= 1'b0;
            opReady1   <= 1'b0;
            opRdValid0 <= 1'b0;
            opRdValid1 <= 1'b0;
            opWrEnable <= 1'b0;
            if (take) begin
                opAddress  <= ADDR_WIDTH'(pick.address);
                opWrData   <= DATA_WIDTH'(pick.wr_data);
                opWrEnable <= pick.wr_enable;
                last_grant <= grant_one;
                opReady0   <= !grant_one;
                opReady1   <= grant_one;
            end
            // Read data for the ISSUE-cycle address is on ipRdData during WAIT.
            if (state == WAIT) begin
                if (last_grant) begin
                    opRdValid1 <= 1'b1;
                    opRdData1  <= ipRdData;
                end else begin
                    opRdValid0 <= 1'b1;
                    opRdData0  <= ipRdData;
                end
            end
        end
    end

endmodule

// File: tb/tb_register_bus_arbiter.sv
// Directed bench for register_bus_arbiter with a small register-file model
// and per-master response scoreboards.
module tb_register_bus_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          ipClk = 1'b0;
    logic          ipReset;
    logic          ipValid0, ipValid1;
    logic [AW-1:0] ipAddress0, ipAddress1;
    logic [DW-1:0] ipWrData0, ipWrData1;
    logic          ipWrEnable0, ipWrEnable1;
    logic          opReady0, opReady1;
    logic          opRdValid0, opRdValid1;
    logic [DW-1:0] opRdData0, opRdData1;
    logic [AW-1:0] opAddress;
    logic [DW-1:0] opWrData;
    logic          opWrEnable;
    logic [DW-1:0] ipRdData;

    logic [DW-1:0] regs [4];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    int total = 0;
    int bad   = 0;

    register_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ipClk(ipClk), .ipReset(ipReset),
        .ipValid0(ipValid0), .ipAddress0(ipAddress0), .ipWrData0(ipWrData0),
        .ipWrEnable0(ipWrEnable0), .opReady0(opReady0), .opRdValid0(opRdValid0),
        .opRdData0(opRdData0),
        .ipValid1(ipValid1), .ipAddress1(ipAddress1), .ipWrData1(ipWrData1),
        .ipWrEnable1(ipWrEnable1), .opReady1(opReady1), .opRdValid1(opRdValid1),
        .opRdData1(opRdData1),
        .opAddress(opAddress), .opWrData(opWrData), .opWrEnable(opWrEnable),
        .ipRdData(ipRdData)
    );

    always #5 ipClk = ~ipClk;

    // Register file: ClockTicks, Buttons, LEDs, FIFO_Size; read-before-write.
    always @(posedge ipClk) begin
        if (ipReset) begin
            regs[0]  <= 32'd0;
            regs[1]  <= 32'hA5;
            regs[2]  <= 32'h0F;
            regs[3]  <= 32'd17;
            ipRdData <= 32'd0;
        end else begin
            ipRdData <= regs[opAddress[1:0]];
            if (opWrEnable) regs[opAddress[1:0]] <= opWrData;
            if (!(opWrEnable && opAddress[1:0] == 2'd0)) regs[0] <= regs[0] + 32'd1;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ipClk);
        #1;
    endtask

    always @(negedge ipClk) begin
        if (opRdValid0 === 1'b1) begin
            total++;
            assert (q0.size() > 0) else begin
                bad++;
                $error("FAIL m0_unexpected_rdvalid observed=pulse expected=none");
            end
            if (q0.size() > 0) chk("m0_rddata_sb", opRdData0, q0.pop_front());
        end
        if (opRdValid1 === 1'b1) begin
            total++;
            assert (q1.size() > 0) else begin
                bad++;
                $error("FAIL m1_unexpected_rdvalid observed=pulse expected=none");
            end
            if (q1.size() > 0) chk("m1_rddata_sb", opRdData1, q1.pop_front());
        end
    end

    initial begin
        ipReset = 1'b1;
        ipValid0 = 1'b0; ipAddress0 = '0; ipWrData0 = '0; ipWrEnable0 = 1'b0;
        ipValid1 = 1'b0; ipAddress1 = '0; ipWrData1 = '0; ipWrEnable1 = 1'b0;
        repeat (3) tick();

        chk("rst_addr",   32'(opAddress), 32'd0);
        chk("rst_wdata",  opWrData, 32'd0);
        chk("rst_we",     32'(opWrEnable), 32'd0);
        chk("rst_rdy0",   32'(opReady0), 32'd0);
        chk("rst_rdy1",   32'(opReady1), 32'd0);
        chk("rst_rv0",    32'(opRdValid0), 32'd0);
        chk("rst_rv1",    32'(opRdValid1), 32'd0);
        chk("rst_rd0",    opRdData0, 32'd0);
        chk("rst_rd1",    opRdData1, 32'd0);
        ipReset = 1'b0;
        tick();

        // master 0 reads FIFO_Size
        ipValid0 = 1'b1; ipAddress0 = 8'h03; ipWrEnable0 = 1'b0;
        q0.push_back(32'd17);
        tick();
        chk("t1_rdy0",  32'(opReady0), 32'd1);
        chk("t1_rdy1",  32'(opReady1), 32'd0);
        chk("t1_addr",  32'(opAddress), 32'h03);
        chk("t1_we",    32'(opWrEnable), 32'd0);
        ipValid0 = 1'b0;
        tick();
        chk("t1_rdy0_off", 32'(opReady0), 32'd0);
        chk("t1_rv0_early", 32'(opRdValid0), 32'd0);
        tick();
        chk("t1_rv0",   32'(opRdValid0), 32'd1);
        chk("t1_rv1",   32'(opRdValid1), 32'd0);
        chk("t1_rd0",   opRdData0, 32'd17);
        tick();

        // master 1 writes LEDs, then reads them back
        ipValid1 = 1'b1; ipAddress1 = 8'h02; ipWrData1 = 32'h5A; ipWrEnable1 = 1'b1;
        q1.push_back(32'h0F);
        tick();
        chk("t2_we",    32'(opWrEnable), 32'd1);
        chk("t2_addr",  32'(opAddress), 32'h02);
        chk("t2_wdata", opWrData, 32'h5A);
        chk("t2_rdy1",  32'(opReady1), 32'd1);
        chk("t2_rdy0",  32'(opReady0), 32'd0);
        ipValid1 = 1'b0;
        tick();
        chk("t2_we_one_cycle", 32'(opWrEnable), 32'd0);
        chk("t2_addr_held", 32'(opAddress), 32'h02);
        tick();
        chk("t2_rv1",   32'(opRdValid1), 32'd1);
        chk("t2_rd1_old", opRdData1, 32'h0F);
        ipValid1 = 1'b1; ipWrEnable1 = 1'b0;
        q1.push_back(32'h5A);
        tick();
        ipValid1 = 1'b0;
        tick();
        tick();
        chk("t2_readback", opRdData1, 32'h5A);
        tick();

        // both masters valid continuously: strict alternation every 3 cycles
        ipValid0 = 1'b1; ipAddress0 = 8'h03; ipWrEnable0 = 1'b0;
        ipValid1 = 1'b1; ipAddress1 = 8'h01; ipWrEnable1 = 1'b0;
        q0.push_back(32'd17); q0.push_back(32'd17);
        q1.push_back(32'hA5); q1.push_back(32'hA5);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("rr_rdy0", 32'(opReady0), 32'((k == 1) || (k == 7)));
            chk("rr_rdy1", 32'(opReady1), 32'((k == 4) || (k == 10)));
        end
        ipValid0 = 1'b0; ipValid1 = 1'b0;
        tick();

        // master 0 requests while master 1 is in WAIT
        ipValid1 = 1'b1; ipAddress1 = 8'h03;
        q1.push_back(32'd17);
        tick();
        chk("t4_rdy1", 32'(opReady1), 32'd1);
        ipValid1 = 1'b0;
        tick();
        ipValid0 = 1'b1; ipAddress0 = 8'h01;
        q0.push_back(32'hA5);
        tick();
        chk("t4_rv1",  32'(opRdValid1), 32'd1);
        chk("t4_rdy0_deferred", 32'(opReady0), 32'd0);
        tick();
        chk("t4_rdy0", 32'(opReady0), 32'd1);
        ipValid0 = 1'b0;
        tick();
        tick();
        chk("t4_rv0",  32'(opRdValid0), 32'd1);
        chk("t4_rd0",  opRdData0, 32'hA5);
        tick();

        // reset during WAIT of a read abandons the transaction
        ipValid0 = 1'b1; ipAddress0 = 8'h03;
        tick();
        chk("t5_rdy0", 32'(opReady0), 32'd1);
        ipValid0 = 1'b0;
        tick();
        ipReset = 1'b1;
        tick();
        chk("t5_rv0",   32'(opRdValid0), 32'd0);
        chk("t5_rd0",   opRdData0, 32'd0);
        chk("t5_rd1",   opRdData1, 32'd0);
        chk("t5_addr",  32'(opAddress), 32'd0);
        chk("t5_rdy0_rst", 32'(opReady0), 32'd0);
        ipReset = 1'b0;
        ipValid0 = 1'b1; ipAddress0 = 8'h03;
        ipValid1 = 1'b1; ipAddress1 = 8'h01;
        q0.push_back(32'd17);
        tick();
        chk("t5_first_rdy0", 32'(opReady0), 32'd1);
        chk("t5_first_rdy1", 32'(opReady1), 32'd0);
        ipValid0 = 1'b0; ipValid1 = 1'b0;
        repeat (4) tick();

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
